// File: rtl/XT_BUS.sv
// Shared high-speed bus slave types plus the tick generator register offsets,
// so firmware headers and RTL agree on one map.
package XT_BUS;

  typedef struct packed {
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } hb_slave_t;

  typedef struct packed {
    logic ren;
    logic wen;
  } sel_t;

  localparam logic [31:0] TICKGEN_CTRL    = 32'h0;
  localparam logic [31:0] TICKGEN_DIV     = 32'h4;
  localparam logic [31:0] TICKGEN_TICKCNT = 32'h8;

  typedef enum logic [1:0] {
    TICKGEN_REG_CTRL    = 2'b00,
    TICKGEN_REG_DIV     = 2'b01,
    TICKGEN_REG_TICKCNT = 2'b10,
    TICKGEN_REG_RSVD    = 2'b11
  } tickgen_reg_e;

endpackage

// File: rtl/tick_divider.sv
// Half-period counter producing the 50% duty timer clock; a new divider
// value is adopted only at a half-period boundary so no runt pulses appear.
module tick_divider #(
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned DEFAULT_HALF = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 halt,
  input  logic [DIV_WIDTH-1:0] div_shadow,
  output logic                 tick_clk,
  output logic                 rise_pulse
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_active;
  logic                 boundary;

  assign boundary   = (cnt == div_active);
  assign rise_pulse = en && !halt && boundary && !tick_clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      tick_clk   <= 1'b0;
      div_active <= DIV_WIDTH'(DEFAULT_HALF - 1);
    end else if (!en) begin
      cnt        <= '0;
      tick_clk   <= 1'b0;
      div_active <= div_shadow;
    end else if (!halt) begin
      if (boundary) begin
        cnt        <= '0;
        tick_clk   <= ~tick_clk;
        div_active <= div_shadow;
      end else begin
        cnt <= cnt + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/system_timer_tick_gen.sv
// Bus-programmable prescaler generating systemtimer_clk from hb_clk, with
// debug-halt freeze and a readable count of generated rising edges.
module system_timer_tick_gen
  import XT_BUS::*;
#(
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned DEFAULT_HALF = 50,
  parameter int unsigned MIN_HALF     = 2
) (
  input  logic        hb_clk,
  input  logic        hb_rst,
  input  hb_slave_t   xt_hb,
  input  sel_t        sel,
  input  logic        halt,
  output logic [31:0] rdata,
  output logic        tick_clk
);

  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_HALF - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_FLOOR = DIV_WIDTH'(MIN_HALF - 1);

  tickgen_reg_e         wsel;
  tickgen_reg_e         rsel;
  logic                 en;
  logic                 en_div;
  logic                 rise_pulse;
  logic                 wr_ctrl;
  logic                 wr_div;
  logic                 wr_cnt;
  logic [DIV_WIDTH-1:0] div_shadow;
  logic [DIV_WIDTH-1:0] div_wr;
  logic [31:0]          tickcnt;
  logic [31:0]          rd_mux;
  logic                 unused_addr;

  assign wsel    = tickgen_reg_e'(xt_hb.waddr[3:2]);
  assign rsel    = tickgen_reg_e'(xt_hb.raddr[3:2]);
  assign wr_ctrl = sel.wen && (wsel == TICKGEN_REG_CTRL);
  assign wr_div  = sel.wen && (wsel == TICKGEN_REG_DIV);
  assign wr_cnt  = sel.wen && (wsel == TICKGEN_REG_TICKCNT);
  assign div_wr  = (xt_hb.wdata[DIV_WIDTH-1:0] < DIV_FLOOR) ? DIV_FLOOR
                                                             : xt_hb.wdata[DIV_WIDTH-1:0];
  assign unused_addr = ^{xt_hb.raddr[31:4], xt_hb.raddr[1:0],
                         xt_hb.waddr[31:4], xt_hb.waddr[1:0]};

  // A same-cycle EN=0 write must beat a half-period boundary, so the
  // divider sees the disable one cycle before the CTRL register does.
  assign en_div = en && !(wr_ctrl && !xt_hb.wdata[0]);

  always_ff @(posedge hb_clk) begin
    if (hb_rst) begin
      en         <= 1'b0;
      div_shadow <= DIV_RESET;
    end else begin
      if (wr_ctrl) en <= xt_hb.wdata[0];
      if (wr_div)  div_shadow <= div_wr;
    end
  end

  always_ff @(posedge hb_clk) begin
    if (hb_rst)          tickcnt <= '0;
    else if (wr_cnt)     tickcnt <= xt_hb.wdata;
    else if (rise_pulse) tickcnt <= tickcnt + 32'd1;
  end

  always_comb begin
    rd_mux = '0;
    unique case (rsel)
      TICKGEN_REG_CTRL:    rd_mux = {31'd0, en};
      TICKGEN_REG_DIV:     rd_mux = 32'(div_shadow);
      TICKGEN_REG_TICKCNT: rd_mux = tickcnt;
      TICKGEN_REG_RSVD:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge hb_clk) begin
    if (hb_rst)       rdata <= '0;
    else if (sel.ren) rdata <= rd_mux;
  end

  tick_divider #(
    .DIV_WIDTH    (DIV_WIDTH),
    .DEFAULT_HALF (DEFAULT_HALF)
  ) u_div (
    .clk        (hb_clk),
    .rst        (hb_rst),
    .en         (en_div),
    .halt       (halt),
    .div_shadow (div_shadow),
    .tick_clk   (tick_clk),
    .rise_pulse (rise_pulse)
  );

endmodule

// File: tb/tb_system_timer_tick_gen.sv
// Scoreboard bench: stimulus queues expected read data and tick_clk samples,
// a negedge monitor pops and compares them against the DUT.
module tb_system_timer_tick_gen;
  import XT_BUS::*;

  logic        hb_clk;
  logic        hb_rst;
  hb_slave_t   xt_hb;
  sel_t        sel;
  logic        halt;
  logic [31:0] rdata;
  logic        tick_clk;

  system_timer_tick_gen #(
    .DIV_WIDTH    (16),
    .DEFAULT_HALF (50),
    .MIN_HALF     (2)
  ) dut (
    .hb_clk   (hb_clk),
    .hb_rst   (hb_rst),
    .xt_hb    (xt_hb),
    .sel      (sel),
    .halt     (halt),
    .rdata    (rdata),
    .tick_clk (tick_clk)
  );

  initial begin
    hb_clk = 1'b0;
    forever #5 hb_clk = ~hb_clk;
  end

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  typedef struct {
    string       name;
    bit          is_rdata;
    logic [31:0] exp;
  } obs_t;

  rd_exp_t rd_q[$];
  obs_t    obs_q[$];
  logic    rd_pend = 1'b0;
  int      n_tests = 0;
  int      n_fail  = 0;

  always @(posedge hb_clk) rd_pend <= sel.ren;

  always @(negedge hb_clk) begin
    rd_exp_t     r;
    obs_t        o;
    logic [31:0] act;
    if (rd_pend) begin
      n_tests++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: rdata 0x%08h with no expectation queued", rdata);
      end else begin
        r = rd_q.pop_front();
        if (rdata !== r.exp) begin
          n_fail++;
          $display("FAIL %s: rdata got 0x%08h expected 0x%08h", r.name, rdata, r.exp);
        end
      end
    end
    while (obs_q.size() > 0) begin
      o   = obs_q.pop_front();
      act = o.is_rdata ? rdata : {31'd0, tick_clk};
      n_tests++;
      if (act !== o.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", o.name, act, o.exp);
      end
    end
  end

  task automatic step();
    @(posedge hb_clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    xt_hb.waddr = a;
    xt_hb.wdata = d;
    sel.wen     = 1'b1;
    step();
    sel.wen     = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    rd_q.push_back('{name: nm, exp: e});
    xt_hb.raddr = a;
    sel.ren     = 1'b1;
    step();
    sel.ren     = 1'b0;
  endtask

  task automatic chk_tick(input logic e, input string nm);
    obs_q.push_back('{name: nm, is_rdata: 1'b0, exp: {31'd0, e}});
  endtask

  task automatic chk_rdata(input logic [31:0] e, input string nm);
    obs_q.push_back('{name: nm, is_rdata: 1'b1, exp: e});
  endtask

  initial begin
    hb_rst = 1'b1;
    halt   = 1'b0;
    sel    = '0;
    xt_hb  = '0;
    repeat (3) step();
    hb_rst = 1'b0;

    // Reset state
    chk_tick(1'b0, "rst_tick");
    chk_rdata(32'd0, "rst_rdata");
    step();
    rd(TICKGEN_CTRL,    32'd0,  "rst_ctrl");
    rd(TICKGEN_DIV,     32'd49, "rst_div");
    rd(TICKGEN_TICKCNT, 32'd0,  "rst_tickcnt");

    // DIV=1: period 4, first rise two cycles after EN lands
    wr(TICKGEN_DIV, 32'd1);
    wr(TICKGEN_CTRL, 32'd1);
    for (int k = 1; k <= 19; k++) begin
      step();
      chk_tick(((k % 4) == 2) || ((k % 4) == 3), $sformatf("div1_k%0d", k));
    end
    rd(TICKGEN_TICKCNT, 32'd5, "div1_tickcnt5");
    wr(TICKGEN_CTRL, 32'd0);
    chk_tick(1'b0, "div1_disabled");

    // Clamping, truncation, reserved slot
    wr(TICKGEN_DIV, 32'd0);
    rd(TICKGEN_DIV, 32'd1, "clamp_div0");
    wr(TICKGEN_DIV, 32'hABCD_0005);
    rd(TICKGEN_DIV, 32'd5, "trunc_div");
    wr(TICKGEN_DIV, 32'h0000_FFFF);
    rd(TICKGEN_DIV, 32'h0000_FFFF, "div_max");
    wr(32'hC, 32'hFFFF_FFFF);
    rd(32'hC, 32'd0, "rsvd_read");
    rd(TICKGEN_CTRL, 32'd0, "rsvd_no_alias");
    wr(TICKGEN_CTRL, 32'd1);
    repeat (300) step();
    chk_tick(1'b0, "div_max_still_low");
    wr(TICKGEN_CTRL, 32'd0);

    // DIV 3 -> 9 written mid high phase: high stays 4, then 10-cycle halves
    wr(TICKGEN_DIV, 32'd3);
    wr(TICKGEN_CTRL, 32'd1);
    for (int k = 1; k <= 28; k++) begin
      if (k == 6) begin
        xt_hb.waddr = TICKGEN_DIV;
        xt_hb.wdata = 32'd9;
        sel.wen     = 1'b1;
      end
      step();
      sel.wen = 1'b0;
      chk_tick(((k >= 4) && (k <= 7)) || ((k >= 18) && (k <= 27)),
               $sformatf("divchg_k%0d", k));
    end
    wr(TICKGEN_CTRL, 32'd0);

    // Halt 7 cycles with tick high and cnt=2: high phase totals 11
    wr(TICKGEN_DIV, 32'd3);
    wr(TICKGEN_CTRL, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      halt = (k >= 7) && (k <= 13);
      step();
      chk_tick(((k >= 4) && (k <= 14)) || (k >= 19), $sformatf("halt_k%0d", k));
    end
    halt = 1'b0;
    wr(TICKGEN_CTRL, 32'd0);

    // TICKCNT wrap, write-wins, disable on a rising boundary
    wr(TICKGEN_TICKCNT, 32'hFFFF_FFFF);
    rd(TICKGEN_TICKCNT, 32'hFFFF_FFFF, "cnt_load");
    wr(TICKGEN_CTRL, 32'd1);
    repeat (3) step();
    chk_tick(1'b0, "wrap_pre_rise");
    step();
    chk_tick(1'b1, "wrap_rise");
    rd(TICKGEN_TICKCNT, 32'd0, "cnt_wrap");
    repeat (6) step();
    wr(TICKGEN_TICKCNT, 32'h0000_0100);
    chk_tick(1'b1, "wrwin_rise");
    rd(TICKGEN_TICKCNT, 32'h0000_0100, "cnt_write_wins");
    repeat (6) step();
    wr(TICKGEN_CTRL, 32'd0);
    chk_tick(1'b0, "dis_boundary");
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_tick(1'b0, $sformatf("dis_hold_k%0d", k));
    end
    rd(TICKGEN_CTRL, 32'd0, "dis_ctrl");
    rd(TICKGEN_TICKCNT, 32'h0000_0100, "dis_cnt_hold");
    step();
    chk_rdata(32'h0000_0100, "rdata_hold");

    // Reset mid-operation while tick_clk is high
    wr(TICKGEN_DIV, 32'd3);
    wr(TICKGEN_CTRL, 32'd1);
    repeat (4) step();
    chk_tick(1'b1, "pre_rst_high");
    hb_rst = 1'b1;
    step();
    hb_rst = 1'b0;
    chk_tick(1'b0, "midrst_tick");
    chk_rdata(32'd0, "midrst_rdata");
    rd(TICKGEN_CTRL,    32'd0,  "midrst_ctrl");
    rd(TICKGEN_DIV,     32'd49, "midrst_div");
    rd(TICKGEN_TICKCNT, 32'd0,  "midrst_tickcnt");

    repeat (3) step();
    n_tests++;
    if ((rd_q.size() != 0) || (obs_q.size() != 0)) begin
      n_fail++;
      $display("FAIL drain: %0d reads and %0d samples left, expected 0 and 0",
               rd_q.size(), obs_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
